// File: rtl/oil_sprite_drawer.sv
// Sprite blitter: walks the sprite ROM in raster order and writes opaque, on-screen pixels
// to the frame buffer at a latched screen position, stalling on fb_ready.
module oil_sprite_drawer #(
  parameter int unsigned SPR_W  = 48,
  parameter int unsigned SPR_H  = 36,
  parameter int unsigned SCR_W  = 640,
  parameter int unsigned SCR_H  = 480,
  parameter logic [23:0] TRANSP = 24'hffffff
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic        busy,
  output logic        done,
  output logic [11:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        fb_we,
  output logic [9:0]  fb_x,
  output logic [9:0]  fb_y,
  output logic [23:0] fb_color,
  input  logic        fb_ready
);

  localparam int unsigned NPix = SPR_W * SPR_H;
  localparam int unsigned ColW = $clog2(SPR_W);
  localparam int unsigned RowW = $clog2(SPR_H + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [9:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic             s1_valid_q, s1_valid_d;
  logic [11:0]      s1_addr_q, s1_addr_d;
  logic [10:0]      s1_x_q, s1_x_d, s1_y_q, s1_y_d;

  logic [11:0] issue_addr;
  logic        clip, stall;

  assign issue_addr = 12'(row_q * SPR_W + col_q);

  // 11-bit coordinates so a sum past 1023 stays clipped instead of wrapping on-screen
  assign clip     = (s1_x_q >= 11'(SCR_W)) || (s1_y_q >= 11'(SCR_H));
  assign fb_we    = s1_valid_q && !clip && (rom_data != TRANSP);
  assign stall    = fb_we && !fb_ready;
  assign rom_addr = stall ? s1_addr_q : issue_addr;
  assign fb_x     = s1_x_q[9:0];
  assign fb_y     = s1_y_q[9:0];
  assign fb_color = rom_data;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pos_x_d = pos_x;
          pos_y_d = pos_y;
          col_d   = '0;
          row_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        busy = 1'b1;
        if (!stall) begin
          s1_valid_d = 1'b1;
          s1_addr_d  = issue_addr;
          s1_x_d     = {1'b0, pos_x_q} + 11'(col_q);
          s1_y_d     = {1'b0, pos_y_q} + 11'(row_q);
          if (col_q == ColW'(SPR_W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (issue_addr == 12'(NPix - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (!stall) begin
          s1_valid_d = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
    end
  end

endmodule

// File: tb/tb_oil_sprite_drawer.sv
// Directed bench for oil_sprite_drawer: one-cycle-latency ROM model, expected-write queue,
// stall, clip, ignored-start and mid-stall reset scenarios.
module tb_oil_sprite_drawer;

  logic        Clk = 1'b0;
  logic        Reset, start, fb_ready;
  logic [9:0]  pos_x, pos_y;
  logic        busy, done, fb_we;
  logic [11:0] rom_addr;
  logic [23:0] rom_data = 24'h0;
  logic [9:0]  fb_x, fb_y;
  logic [23:0] fb_color;

  oil_sprite_drawer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_we    (fb_we),
    .fb_x     (fb_x),
    .fb_y     (fb_y),
    .fb_color (fb_color),
    .fb_ready (fb_ready)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  typedef struct {
    int          addr;
    int          x;
    int          y;
    logic [23:0] c;
  } pix_t;

  pix_t expq[$];
  int   nwrites, stalls, first_cnt, done_cnt, first_x, first_y, last_x, last_y;

  function automatic logic [23:0] rom_fn(input logic [11:0] a);
    case (mode)
      0:       return 24'h000000;
      1:       return a[0] ? {12'h123, a} : 24'hffffff;
      default: return {12'habc, a};
    endcase
  endfunction

  // ROM with one-cycle read latency
  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input int px, input int py);
    pix_t e;
    logic [11:0] a;
    expq.delete();
    for (int p = 0; p < 1728; p++) begin
      a      = p[11:0];
      e.addr = p;
      e.x    = px + p % 48;
      e.y    = py + p / 48;
      e.c    = rom_fn(a);
      if (e.c != 24'hffffff && e.x < 640 && e.y < 480) expq.push_back(e);
    end
  endtask

  task automatic run_draw(input int px, input int py, input int pct, input int inject_at);
    pix_t f;
    build(px, py);
    nwrites = 0; stalls = 0; first_cnt = -1; done_cnt = -1;
    @(negedge Clk);
    start = 1'b1; pos_x = px[9:0]; pos_y = py[9:0]; fb_ready = 1'b1;
    for (int cnt = 0; cnt < 8000; cnt++) begin
      @(negedge Clk);
      start = (cnt == inject_at);
      pos_x = (cnt == inject_at) ? 10'd0 : px[9:0];
      pos_y = (cnt == inject_at) ? 10'd0 : py[9:0];
      fb_ready = (pct == 0) ? 1'b1 : ($urandom_range(99) >= pct);
      #1;
      if (fb_we) begin
        if (expq.size() == 0) begin
          chk("extra_write", 32'(fb_we), 32'd0);
        end else begin
          f = expq[0];
          if (fb_ready) begin
            chk("wr_x", 32'(fb_x), f.x);
            chk("wr_y", 32'(fb_y), f.y);
            chk("wr_color", 32'(fb_color), 32'(f.c));
            void'(expq.pop_front());
            if (first_cnt < 0) begin
              first_cnt = cnt; first_x = f.x; first_y = f.y;
            end
            last_x = f.x; last_y = f.y;
            nwrites++;
          end else begin
            stalls++;
            chk("stall_rom_addr", 32'(rom_addr), f.addr);
            chk("stall_x", 32'(fb_x), f.x);
            chk("stall_y", 32'(fb_y), f.y);
            chk("stall_color", 32'(fb_color), 32'(f.c));
          end
        end
      end
      if (done) begin
        done_cnt = cnt;
        chk("busy_at_done", 32'(busy), 32'd0);
        break;
      end
      chk("busy_during_draw", 32'(busy), 32'd1);
    end
    start = 1'b0;
    fb_ready = 1'b1;
    if (done_cnt < 0) chk("done_timeout", 32'd0, 32'd1);
    chk("done_cycle", done_cnt, 1729 + stalls);
    chk("queue_empty", expq.size(), 32'd0);
    @(negedge Clk); #1;
    chk("done_one_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_we", 32'(fb_we), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; pos_x = '0; pos_y = '0; fb_ready = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_fb_x", 32'(fb_x), 32'd0);
    chk("rst_fb_y", 32'(fb_y), 32'd0);
    Reset = 1'b0;

    // all-opaque full draw
    mode = 0;
    run_draw(100, 50, 0, -1);
    chk("t1_writes", nwrites, 1728);
    chk("t1_first_cnt", first_cnt, 1);
    chk("t1_first_x", first_x, 100);
    chk("t1_first_y", first_y, 50);
    chk("t1_last_x", last_x, 147);
    chk("t1_last_y", last_y, 85);
    chk("t1_done_cnt", done_cnt, 1729);

    // transparent at even addresses
    mode = 1;
    run_draw(0, 0, 0, -1);
    chk("t2_writes", nwrites, 864);
    chk("t2_first_x", first_x, 1);
    chk("t2_done_cnt", done_cnt, 1729);

    // bottom-right clipping
    mode = 0;
    run_draw(620, 470, 0, -1);
    chk("t3_writes", nwrites, 200);
    chk("t3_first_x", first_x, 620);
    chk("t3_first_y", first_y, 470);
    chk("t3_last_x", last_x, 639);
    chk("t3_last_y", last_y, 479);
    chk("t3_done_cnt", done_cnt, 1729);

    // random backpressure
    mode = 2;
    run_draw(200, 100, 30, -1);
    chk("t4_writes", nwrites, 1728);
    chk("t4_stalled", 32'(stalls > 0), 32'd1);

    // start while busy is ignored
    run_draw(300, 200, 0, 100);
    chk("t5_writes", nwrites, 1728);
    chk("t5_first_x", first_x, 300);
    chk("t5_last_y", last_y, 235);

    // reset while pixel 500 is stalled
    mode = 0;
    @(negedge Clk);
    start = 1'b1; pos_x = 10'd10; pos_y = 10'd10;
    for (int cnt = 0; cnt <= 501; cnt++) begin
      @(negedge Clk);
      start = 1'b0;
      fb_ready = (cnt != 501);
      #1;
    end
    chk("t6_stall_we", 32'(fb_we), 32'd1);
    chk("t6_stall_addr", 32'(rom_addr), 32'd500);
    chk("t6_stall_x", 32'(fb_x), 32'd30);
    chk("t6_stall_y", 32'(fb_y), 32'd20);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; fb_ready = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_we", 32'(fb_we), 32'd0);
    chk("t6_rom_addr", 32'(rom_addr), 32'd0);
    run_draw(5, 7, 0, -1);
    chk("t6_writes", nwrites, 1728);
    chk("t6_first_x", first_x, 5);
    chk("t6_last_x", last_x, 52);
    chk("t6_last_y", last_y, 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
